trap_draw_scheduler: RTL and testbench

- Sequences the trap/lava colour lookup across a rectangular screen region, one pixel per accepted cycle.
- Drives x_cord/y_cord into the traps lookup block and pairs the registered flag that comes back with the matching coordinate.
- Issues plot writes to the VGA adapter path, with backpressure.
- Sits between the game FSM (which requests a redraw) and the VGA adapter.

---
 rtl/game_pkg.sv | 10 +
 rtl/trap_draw_scheduler_raster_counter.sv | 29 ++
 rtl/trap_draw_scheduler.sv | 82 ++++++++
 tb/tb_trap_draw_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: colours, trap region bounds and draw-scheduler state encoding shared across the game.
package game_pkg;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [8:0] TRAP_X_MIN = 9'd60;
    localparam logic [8:0] TRAP_X_MAX = 9'd240;
    localparam logic [8:0] TRAP_Y_MIN = 9'd123;
    localparam logic [8:0] TRAP_Y_MAX = 9'd250;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} draw_state_t;
endpackage

// File: rtl/trap_draw_scheduler_raster_counter.sv
// raster_counter: x-first raster walk over an inclusive rectangle, back to origin after the last pixel.
module raster_counter
    import game_pkg::*;
#(
    parameter logic [8:0] X_MIN = TRAP_X_MIN,
    parameter logic [8:0] X_MAX = TRAP_X_MAX,
    parameter logic [8:0] Y_MIN = TRAP_Y_MIN,
    parameter logic [8:0] Y_MAX = TRAP_Y_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       last
);
    logic x_end;
    assign x_end = x == X_MAX;
    assign last = x_end && y == Y_MAX;
    always_ff @(posedge clock) begin
        if (reset || (en && last)) begin
            x <= X_MIN;
            y <= Y_MIN;
        end else if (en) begin
            x <= x_end ? X_MIN : x + 9'd1;
            y <= x_end ? y + 9'd1 : y;
        end
    end
endmodule

// File: rtl/trap_draw_scheduler.sv
// trap_draw_scheduler: scans the trap region through the traps lookup and streams plot writes
// to the VGA path, one pixel per accepted cycle with plot_ready backpressure.
module trap_draw_scheduler
    import game_pkg::*;
#(
    parameter logic [8:0] X_MIN = TRAP_X_MIN,
    parameter logic [8:0] X_MAX = TRAP_X_MAX,
    parameter logic [8:0] Y_MIN = TRAP_Y_MIN,
    parameter logic [8:0] Y_MAX = TRAP_Y_MAX,
    parameter logic SKIP_BLACK = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [8:0] x_cord,
    output logic [8:0] y_cord,
    input  logic [2:0] flag,
    output logic       plot,
    output logic [8:0] plot_x,
    output logic [8:0] plot_y,
    output logic [2:0] plot_colour,
    input  logic       plot_ready,
    output logic       busy,
    output logic       done
);
    draw_state_t state, state_next;
    logic [8:0] scan_x, scan_y, s1_x, s1_y;
    logic [2:0] s1_colour, colour;
    logic s1_valid, s1_fresh, scan_last, skip_pixel, s1_accept, adv, issue;

    raster_counter #(.X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) u_counter (
        .clock(clock), .reset(reset), .en(issue), .x(scan_x), .y(scan_y), .last(scan_last)
    );

    // During a stall the lookup already sees the next coordinate, so the colour
    // arriving on the first stage-1 cycle is kept locally until the write is accepted.
    assign colour = s1_fresh ? flag : s1_colour;
    assign skip_pixel = SKIP_BLACK && colour == BLACK;
    assign s1_accept = s1_valid && (plot_ready || skip_pixel);
    assign adv = !s1_valid || s1_accept;
    assign issue = state == SCAN && adv;
    assign x_cord = scan_x;
    assign y_cord = scan_y;
    assign plot = s1_valid && !skip_pixel;
    assign plot_x = s1_x;
    assign plot_y = s1_y;
    assign plot_colour = s1_valid ? colour : BLACK;
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
            s1_x <= 9'd0;
            s1_y <= 9'd0;
            s1_colour <= BLACK;
        end else if (adv) begin
            s1_valid <= issue;
            s1_fresh <= issue;
            if (issue) begin
                s1_x <= scan_x;
                s1_y <= scan_y;
            end
        end else begin
            s1_fresh <= 1'b0;
            s1_colour <= colour;
        end
    end

    always_ff @(posedge clock) state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? SCAN : IDLE;
            SCAN:    state_next = issue && scan_last ? DRAIN : SCAN;
            DRAIN:   state_next = s1_accept ? DONE : DRAIN;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_draw_scheduler.sv
// tb_trap_draw_scheduler: three scheduler instances (full trap region, small lava patch, single pixel)
// driven against a behavioural traps map, with a queue scoreboard checking every accepted write.
module tb_trap_draw_scheduler;
    typedef struct packed {logic [8:0] x; logic [8:0] y; logic [2:0] c;} px_t;
    localparam int N = 3;
    localparam int XL[N] = '{60, 75, 5};
    localparam int XH[N] = '{240, 80, 5};
    localparam int YL[N] = '{123, 236, 7};
    localparam int YH[N] = '{250, 237, 7};
    localparam bit SK[N] = '{1'b0, 1'b1, 1'b1};

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] start = '0, ready = '1, plot, busy, done;
    logic [8:0] x_cord[N], y_cord[N], plot_x[N], plot_y[N];
    logic [2:0] flag[N], plot_colour[N];
    px_t exp_q[N][$];
    int vectors = 0, miscompares = 0;
    int done_cnt[N];

    always #5 clk = ~clk;

    function automatic logic [2:0] colour_of(input int x, input int y);
        if (y >= 184 && y <= 190) return 3'b100;
        if (y >= 230 && x >= 70 && x <= 90) return 3'b100;
        if (x < 20) return 3'b001;
        if ((x * 7 + y * 3) % 11 == 0) return 3'((x + y) % 8);
        return 3'b000;
    endfunction

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, g, act, expv);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : inst
        logic held = 1'b0;
        px_t held_px;
        trap_draw_scheduler #(
            .X_MIN(9'(XL[g])), .X_MAX(9'(XH[g])), .Y_MIN(9'(YL[g])), .Y_MAX(9'(YH[g])), .SKIP_BLACK(SK[g])
        ) dut (
            .clock(clk), .reset(rst), .start(start[g]), .x_cord(x_cord[g]), .y_cord(y_cord[g]),
            .flag(flag[g]), .plot(plot[g]), .plot_x(plot_x[g]), .plot_y(plot_y[g]),
            .plot_colour(plot_colour[g]), .plot_ready(ready[g]), .busy(busy[g]), .done(done[g])
        );
        always @(posedge clk) flag[g] <= colour_of(int'(x_cord[g]), int'(y_cord[g]));
        always @(negedge clk) begin
            if (held && !rst)
                check("stall_hold", g, 32'({plot[g], plot_x[g], plot_y[g], plot_colour[g]}), 32'({1'b1, held_px}));
            if (plot[g] && ready[g] && !rst) begin
                if (exp_q[g].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_plot inst%0d: got (%0d,%0d) c=%0d, expected no write", g, plot_x[g], plot_y[g], plot_colour[g]);
                end else
                    check("plot", g, 32'({plot_x[g], plot_y[g], plot_colour[g]}), 32'(exp_q[g].pop_front()));
            end
            if (done[g] && !rst) begin
                done_cnt[g]++;
                check("done_drained", g, 32'(exp_q[g].size()), 32'd0);
            end
            held = plot[g] && !ready[g] && !rst;
            held_px = {plot_x[g], plot_y[g], plot_colour[g]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int g);
        for (int y = YL[g]; y <= YH[g]; y++)
            for (int x = XL[g]; x <= XH[g]; x++)
                if (!SK[g] || colour_of(x, y) != 3'b000) exp_q[g].push_back({9'(x), 9'(y), colour_of(x, y)});
    endtask

    task automatic check_reset(input int g);
        check("reset_ctl", g, 32'({plot[g], busy[g], done[g]}), 32'd0);
        check("reset_cord", g, 32'({x_cord[g], y_cord[g]}), 32'({9'(XL[g]), 9'(YL[g])}));
        check("reset_plot_xy", g, 32'({plot_x[g], plot_y[g]}), 32'd0);
    endtask

    task automatic launch(input int g);
        fill(g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        check("entry_busy_noplot", g, 32'({busy[g], plot[g]}), 32'(2'b10));
        tick();
        check("first_plot", g, 32'({plot[g], plot_x[g], plot_y[g]}), 32'({1'b1, 9'(XL[g]), 9'(YL[g])}));
    endtask

    task automatic wait_idle(input int g, input int budget, input int px, input int py, output int n);
        bit pulsed = 1'b0;
        n = 2;
        forever begin
            start[g] = !pulsed && plot[g] && plot_x[g] == 9'(px) && plot_y[g] == 9'(py);
            pulsed |= start[g];
            tick();
            if (!busy[g]) break;
            n++;
            if (n > budget) begin
                vectors++;
                miscompares++;
                $display("FAIL busy_timeout inst%0d: busy still high after %0d cycles, expected idle", g, n);
                break;
            end
        end
        start[g] = 1'b0;
    endtask

    initial begin
        int n;
        bit stalled;
        repeat (3) tick();
        for (int g = 0; g < N; g++) check_reset(g);
        rst = 1'b0;
        tick();
        launch(1);
        wait_idle(1, 100, 511, 511, n);
        check("busy_cycles", 1, 32'(n), 32'd14);
        check("done_count", 1, 32'(done_cnt[1]), 32'd1);
        launch(2);
        wait_idle(2, 100, 511, 511, n);
        check("busy_cycles", 2, 32'(n), 32'd3);
        check("done_count", 2, 32'(done_cnt[2]), 32'd1);
        // full region with random backpressure, a directed 5-cycle stall, then reset while draining
        launch(0);
        stalled = 1'b0;
        n = 0;
        while (!rst && n < 40000) begin
            n++;
            ready[0] = $urandom_range(7) != 0;
            if (!stalled && plot[0] && plot_x[0] == 9'd100 && plot_y[0] == 9'd126) begin
                stalled = 1'b1;
                ready[0] = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check("stall_xcord", 0, 32'({x_cord[0], y_cord[0]}), 32'({9'd101, 9'd126}));
                end
                ready[0] = 1'b1;
            end else if (plot[0] && plot_x[0] == 9'd240 && plot_y[0] == 9'd250) begin
                ready[0] = 1'b0;
                rst = 1'b1;
            end
            tick();
        end
        if (!rst) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout inst0: last pixel (240,250) never presented within %0d cycles", n);
            rst = 1'b1;
            tick();
        end
        check("stall_seen", 0, 32'(stalled), 32'd1);
        check_reset(0);
        check("dropped_tail", 0, 32'(exp_q[0].size()), 32'd1);
        check("done_count_aborted", 0, 32'(done_cnt[0]), 32'd0);
        exp_q[0].delete();
        rst = 1'b0;
        ready[0] = 1'b1;
        tick();
        launch(0);
        wait_idle(0, 30000, 150, 130, n);
        check("busy_cycles", 0, 32'(n), 32'd23170);
        check("done_count", 0, 32'(done_cnt[0]), 32'd1);
        repeat (3) tick();
        check("stays_idle", 0, 32'(busy[0]), 32'd0);
        check("queue_empty", 0, 32'(exp_q[0].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
